main: RTL and testbench
=======================

MAIN -- requirements
Module: main

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset; sampled on rising clk edge.
REQ-003 data  input  1  pulse input, delay-line A.
REQ-004 data2  input  1  pulse input, delay-line B / counter restart.
REQ-005 datadelay0  output  1  data with 0-cycle delay (combinational copy).
REQ-006 datadelay2, datadelay8, datadelay14, datadelay18, datadelay19  output  1 each  data delayed by 2/8/14/18/19 clk cycles.
REQ-007 delay0  output  1  data2 with 0-cycle delay (combinational copy).
REQ-008 delay1, delay5  output  1 each  data2 delayed by 1/5 clk cycles.
REQ-009 hebo  output  1  merged pulse train: delay0 | delay1 | delay5.
REQ-010 gie  output  1  window flag between delay1 and delay5.
REQ-011 gie2  output  1  gie delayed one clk cycle.
REQ-012 b3  output  1  decode flag, high while cnt == 3.
REQ-013 cnt  output  5  cycles elapsed since the last data2 pulse, saturating.

Function
REQ-014 Line A SHALL be a 19-stage shift register sa[1..19]: sa[1] <= data, sa[k] <= sa[k-1]; datadelayN = sa[N] for N in {2,8,14,18,19}.
REQ-015 A 1-cycle data pulse sampled at edge E SHALL appear on datadelayN for exactly one cycle, asserted after edge E+N-1 (N-th edge counting E as first).
REQ-016 datadelay0 and delay0 SHALL be purely combinational copies of data and data2, unaffected by rst.
REQ-017 Line B SHALL be a 5-stage shift register sb[1..5] fed by data2; delay1 = sb[1], delay5 = sb[5].
REQ-018 hebo SHALL be combinational OR of delay0, delay1, delay5; no extra latency.
REQ-019 gie SHALL be a register: next = 1 when delay1 = 1 and delay5 = 0; next = 0 when delay5 = 1 (clear wins on simultaneous set and clear); else hold.
REQ-020 For an isolated 1-cycle data2 pulse, gie SHALL be high for 4 consecutive cycles, starting one cycle after delay1 asserts and ending on the edge on which delay5 is high.
REQ-021 gie2 SHALL be gie registered once (1-cycle lag).
REQ-022 cnt SHALL load 0 on any edge where data2 = 1; otherwise increment by 1 and saturate at 31 (no wrap).
REQ-023 b3 SHALL be combinational (cnt == 5'd3).
REQ-024 Back-to-back or multi-cycle pulses on data/data2 SHALL propagate bit-exactly through the shift registers; no pulse merging or filtering.
REQ-025 Pulse period of 19 cycles SHALL be supported with no interference between successive pulses on any output.

Reset
REQ-026 While rst = 1 at a rising edge, all shift-register stages, gie, gie2 and cnt SHALL clear to 0; hence datadelay2..19, delay1, delay5, gie, gie2, cnt = 0 on the following cycle.
REQ-027 During reset, b3 SHALL be 0 (cnt = 0); hebo SHALL equal delay0, and datadelay0 SHALL equal data.
REQ-028 Reset asserted mid-propagation SHALL discard all in-flight pulses; none reappear after reset release.
REQ-029 First rising edge with rst = 0 SHALL resume normal operation (shift/count) immediately.

Verification
REQ-030 Reset, then 1-cycle data pulse at edge E -> datadelay2/8/14/18/19 each high for exactly one cycle after edges E+1/E+7/E+13/E+17/E+18; datadelay0 high in the cycle of the pulse.
REQ-031 1-cycle data2 pulse -> hebo high in three separate single cycles (offsets 0, 1, 5); gie high 4 cycles; gie2 same shape, 1 cycle later.
REQ-032 data2 pulse, then idle -> cnt = 0,1,2,...,31 and holds at 31; b3 high for exactly one cycle, when cnt = 3.
REQ-033 Pulses on data and data2 every 19 cycles (1 high, 18 low), five repetitions -> each delayed output pulses once per period; datadelay19 coincides with the next datadelay0 pulse; cnt peaks at 18 then resets to 0.
REQ-034 rst asserted 10 cycles after a data pulse -> datadelay14/18/19 never assert; cnt = 0 after reset.
REQ-035 data2 held high 3 cycles -> delay5 high 3 cycles; gie cleared on first delay5 edge; cnt stays 0 while data2 is high.

Source files
------------

// File: rtl/main.sv
// Pulse delay lines: data through a 19-stage line, data2 through a 5-stage line,
// plus a delay1..delay5 window flag and a saturating cycle counter restarted by data2.
module main (
  input  logic       clk,
  input  logic       rst,
  input  logic       data,
  input  logic       data2,
  output logic       datadelay0,
  output logic       datadelay2,
  output logic       datadelay8,
  output logic       datadelay14,
  output logic       datadelay18,
  output logic       datadelay19,
  output logic       delay0,
  output logic       delay1,
  output logic       delay5,
  output logic       hebo,
  output logic       gie,
  output logic       gie2,
  output logic       b3,
  output logic [4:0] cnt
);

  localparam logic [4:0] CNT_MAX = 5'd31;

  logic [19:1] sa_q;
  logic [5:1]  sb_q;
  logic        gie_q, gie_d;
  logic        gie2_q;
  logic [4:0]  cnt_q, cnt_d;

  // Clear has priority so a delay5 edge always closes the window.
  always_comb begin
    gie_d = gie_q;
    if (sb_q[5]) begin
      gie_d = 1'b0;
    end else if (sb_q[1]) begin
      gie_d = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (data2) begin
      cnt_d = 5'd0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sa_q   <= '0;
      sb_q   <= '0;
      gie_q  <= 1'b0;
      gie2_q <= 1'b0;
      cnt_q  <= 5'd0;
    end else begin
      sa_q   <= {sa_q[18:1], data};
      sb_q   <= {sb_q[4:1], data2};
      gie_q  <= gie_d;
      gie2_q <= gie_q;
      cnt_q  <= cnt_d;
    end
  end

  assign datadelay0  = data;
  assign datadelay2  = sa_q[2];
  assign datadelay8  = sa_q[8];
  assign datadelay14 = sa_q[14];
  assign datadelay18 = sa_q[18];
  assign datadelay19 = sa_q[19];

  assign delay0 = data2;
  assign delay1 = sb_q[1];
  assign delay5 = sb_q[5];
  assign hebo   = data2 | sb_q[1] | sb_q[5];

  assign gie  = gie_q;
  assign gie2 = gie2_q;
  assign cnt  = cnt_q;
  assign b3   = (cnt_q == 5'd3);

endmodule

// File: tb/tb_main.sv
// Directed bench for main: a hand-computed vector table plus multi-cycle
// sequences for delay taps, counter saturation, periodic pulses and reset.
module tb_main;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       data = 1'b0;
  logic       data2 = 1'b0;
  logic       datadelay0, datadelay2, datadelay8, datadelay14, datadelay18, datadelay19;
  logic       delay0, delay1, delay5, hebo, gie, gie2, b3;
  logic [4:0] cnt;

  int checks = 0;
  int failures = 0;

  main dut (
    .clk(clk), .rst(rst), .data(data), .data2(data2),
    .datadelay0(datadelay0), .datadelay2(datadelay2), .datadelay8(datadelay8),
    .datadelay14(datadelay14), .datadelay18(datadelay18), .datadelay19(datadelay19),
    .delay0(delay0), .delay1(delay1), .delay5(delay5), .hebo(hebo),
    .gie(gie), .gie2(gie2), .b3(b3), .cnt(cnt)
  );

  always #5 clk = ~clk;

  logic [5:0] dd_vec;
  logic [5:0] b_vec;
  assign dd_vec = {datadelay0, datadelay2, datadelay8, datadelay14, datadelay18, datadelay19};
  assign b_vec  = {delay0, delay1, delay5, hebo, gie, gie2};

  typedef struct {
    logic       r;
    logic       d;
    logic       d2;
    logic [5:0] exp_dd;
    logic [5:0] exp_b;
    logic       exp_b3;
    logic [4:0] exp_cnt;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one cycle: drive inputs just after the rising edge, return at the falling edge.
  task automatic cyc(input logic r, input logic d, input logic d2);
    @(posedge clk);
    #1;
    rst = r;
    data = d;
    data2 = d2;
    @(negedge clk);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  initial begin
    // rows: rst, data, data2, {dd0,dd2,dd8,dd14,dd18,dd19}, {delay0,delay1,delay5,hebo,gie,gie2}, b3, cnt
    tbl[0] = '{1'b1, 1'b0, 1'b0, 6'b000000, 6'b000000, 1'b0, 5'd0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 6'b100000, 6'b100100, 1'b0, 5'd0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 6'b000000, 6'b010100, 1'b0, 5'd0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 6'b010000, 6'b000010, 1'b0, 5'd1};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 6'b000000, 6'b000011, 1'b0, 5'd2};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 6'b000000, 6'b000011, 1'b1, 5'd3};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 6'b000000, 6'b001111, 1'b0, 5'd4};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 6'b000000, 6'b000001, 1'b0, 5'd5};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 6'b000000, 6'b000000, 1'b0, 5'd6};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 6'b001000, 6'b000000, 1'b0, 5'd7};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].r, tbl[i].d, tbl[i].d2);
      chk($sformatf("tbl%0d_dd", i), dd_vec, tbl[i].exp_dd);
      chk($sformatf("tbl%0d_b", i), b_vec, tbl[i].exp_b);
      chk($sformatf("tbl%0d_b3", i), b3, tbl[i].exp_b3);
      chk($sformatf("tbl%0d_cnt", i), cnt, tbl[i].exp_cnt);
      $display("row %0d rst=%0b data=%0b data2=%0b dd=%b b=%b b3=%0b cnt=%0d",
               i, tbl[i].r, tbl[i].d, tbl[i].d2, dd_vec, b_vec, b3, cnt);
    end

    // Single pulse on both lines: every tap once at its own offset; counter saturates.
    do_reset();
    for (int k = 0; k <= 40; k++) begin
      cyc(1'b0, k == 0, k == 0);
      chk($sformatf("single_dd_k%0d", k), dd_vec,
          {k == 0, k == 2, k == 8, k == 14, k == 18, k == 19});
      if (k >= 1) begin
        chk($sformatf("single_cnt_k%0d", k), cnt, imin(k - 1, 31));
        chk($sformatf("single_b3_k%0d", k), b3, k == 4);
      end
    end
    $display("single pulse sequence done cnt=%0d", cnt);

    // Pulses every 19 cycles, five times.
    do_reset();
    for (int t = 0; t <= 110; t++) begin
      logic pulse;
      logic [5:0] exp_dd;
      int p;
      pulse = (t % 19 == 0) && (t / 19 < 5);
      cyc(1'b0, pulse, pulse);
      exp_dd[5] = pulse;
      exp_dd[4] = (t >= 2)  && ((t - 2)  % 19 == 0) && ((t - 2)  / 19 < 5);
      exp_dd[3] = (t >= 8)  && ((t - 8)  % 19 == 0) && ((t - 8)  / 19 < 5);
      exp_dd[2] = (t >= 14) && ((t - 14) % 19 == 0) && ((t - 14) / 19 < 5);
      exp_dd[1] = (t >= 18) && ((t - 18) % 19 == 0) && ((t - 18) / 19 < 5);
      exp_dd[0] = (t >= 19) && ((t - 19) % 19 == 0) && ((t - 19) / 19 < 5);
      chk($sformatf("period_dd_t%0d", t), dd_vec, exp_dd);
      if (t >= 1) begin
        p = imin(19 * ((t - 1) / 19), 76);
        chk($sformatf("period_cnt_t%0d", t), cnt, imin(t - p - 1, 31));
      end else begin
        chk("period_cnt_t0", cnt, 0);
      end
    end
    $display("periodic sequence done cnt=%0d", cnt);

    // Reset mid-flight discards pending pulses, then counting resumes at once.
    do_reset();
    for (int t = 0; t <= 30; t++) begin
      cyc(t == 10, t == 0, t == 0);
      if (t >= 11) begin
        chk($sformatf("midrst_late_t%0d", t), {datadelay14, datadelay18, datadelay19}, 3'b000);
        chk($sformatf("midrst_cnt_t%0d", t), cnt, t - 11);
      end
      if (t == 11) begin
        chk("midrst_dd_clear", dd_vec, 6'b000000);
        chk("midrst_b_clear", b_vec, 6'b000000);
      end
    end
    $display("mid-flight reset sequence done cnt=%0d", cnt);

    // data2 held high three cycles.
    do_reset();
    for (int t = 0; t <= 10; t++) begin
      cyc(1'b0, 1'b0, t <= 2);
      chk($sformatf("hold_delay5_t%0d", t), delay5, (t >= 5) && (t <= 7));
      chk($sformatf("hold_gie_t%0d", t), gie, (t >= 2) && (t <= 5));
      if (t <= 4) begin
        chk($sformatf("hold_cnt_t%0d", t), cnt, (t == 4) ? 1 : 0);
      end
    end
    $display("held data2 sequence done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
